// File: rtl/uart_tx_frame_engine.sv
// uart_tx_frame_engine: parametrised UART transmitter.
//   Frame = START(0), DATA_WIDTH data bits LSB first, optional parity, 1 or 2 STOP(1) bits.
//   Frames go back-to-back with no idle gap when the source keeps Data_Valid high.
// Ports:
//   CLK, RST        clock (rising edge) and asynchronous active-low reset
//   P_DATA          parallel data word, latched on acceptance
//   Data_Valid      source has a word on P_DATA
//   Data_Ack        pulse in the cycle P_DATA is accepted
//   PAR_EN/PAR_TYP  parity enable / odd(1) or even(0) parity, latched on acceptance
//   STOP2           two stop bits when high, latched on acceptance
//   Prescale        bit period = Prescale+1 CLK cycles, latched on acceptance
//   Send_Break      (UART_TX_BREAK_EN only) request a break condition from idle
//   TX_OUT          registered serial line, idle high
//   busy            high while a frame (or break) is on the line
// Optional feature: define UART_TX_BREAK_EN to add Send_Break and the BREAK state.
module uart_tx_frame_engine #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    output logic                      Data_Ack,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
`ifdef UART_TX_BREAK_EN
    input  logic                      Send_Break,
`endif
    output logic                      TX_OUT,
    output logic                      busy
);

    // Wide enough for the data index, the stop-bit index and the break bit count (max 13).
    localparam int unsigned IdxW = 4;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
`ifdef UART_TX_BREAK_EN
        , StBreak = 3'd5
`endif
    } state_e;

    state_e                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] baud_q, baud_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;     // shifts right as bits go out
    logic                      par_q, par_d;       // parity bit, computed at acceptance
    logic                      par_en_q, par_en_d;
    logic                      stop2_q, stop2_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      bit_end;
    logic                      accept;
`ifdef UART_TX_BREAK_EN
    logic [IdxW-1:0]           brk_len_q, brk_len_d;
`endif

    assign bit_end  = (baud_q == prescale_q);
    assign Data_Ack = accept;
    assign TX_OUT   = tx_q;
    assign busy     = busy_q;

    // State register, including the registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            prescale_q <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_len_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            prescale_q <= prescale_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            par_q      <= par_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef UART_TX_BREAK_EN
            brk_len_q  <= brk_len_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        idx_d      = idx_q;
        data_d     = data_q;
        par_d      = par_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        accept     = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_len_d  = brk_len_q;
`endif
        baud_d = (bit_end || state_q == StIdle) ? '0 : baud_q + PRESCALE_WIDTH'(1);

        case (state_q)
            StIdle: begin
`ifdef UART_TX_BREAK_EN
                // Break wins over data; it reuses the stop state with a single stop bit.
                if (Send_Break) begin
                    state_d    = StBreak;
                    idx_d      = '0;
                    prescale_d = Prescale;
                    stop2_d    = 1'b0;
                    brk_len_d  = IdxW'(DATA_WIDTH + 2) + IdxW'(PAR_EN) + IdxW'(STOP2);
                end else
`endif
                if (Data_Valid) begin
                    accept = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    idx_d   = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    data_d = data_q >> 1;
                    if (idx_q == LastIdx) begin
                        state_d = par_en_q ? StParity : StStop;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    idx_d   = '0;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (idx_q == {{(IdxW-1){1'b0}}, stop2_q}) begin
                        if (Data_Valid) begin
                            accept = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            StBreak: begin
                if (bit_end) begin
                    if (idx_q >= brk_len_q - IdxW'(1) && !Send_Break) begin
                        state_d = StStop;
                        idx_d   = '0;
                    end else if (idx_q != '1) begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
`endif
            default: begin
                state_d = StIdle;
                idx_d   = '0;
                baud_d  = '0;
            end
        endcase

        if (accept) begin
            state_d    = StStart;
            idx_d      = '0;
            baud_d     = '0;
            data_d     = P_DATA;
            par_d      = (^P_DATA) ^ PAR_TYP;
            par_en_d   = PAR_EN;
            stop2_d    = STOP2;
            prescale_d = Prescale;
        end
    end

    // Output logic: computed from the next state so the line is registered.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            StIdle:   busy_d = 1'b0;
            StStart:  tx_d   = 1'b0;
            StData:   tx_d   = data_d[0];
            StParity: tx_d   = par_d;
            StStop:   tx_d   = 1'b1;
`ifdef UART_TX_BREAK_EN
            StBreak:  tx_d   = 1'b0;
`endif
            default: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Scoreboard bench for uart_tx_frame_engine: the driver pushes the expected line waveform of
// each accepted frame; a monitor checks TX_OUT, busy and Data_Ack every cycle.
module tb_uart_tx_frame_engine;

    localparam int DW = 8;
    localparam int PW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          STOP2 = 1'b0;
    logic [PW-1:0] Prescale = '0;
    logic          Data_Ack;
    logic          TX_OUT;
    logic          busy;
`ifdef UART_TX_BREAK_EN
    logic          Send_Break = 1'b0;
`endif

    uart_tx_frame_engine #(
        .DATA_WIDTH(DW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .P_DATA(P_DATA),
        .Data_Valid(Data_Valid),
        .Data_Ack(Data_Ack),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .STOP2(STOP2),
        .Prescale(Prescale),
`ifdef UART_TX_BREAK_EN
        .Send_Break(Send_Break),
`endif
        .TX_OUT(TX_OUT),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] bits;   // line level of each bit period, in order
        int          nbits;
        int          per;    // cycles per bit
    } frame_t;

    frame_t sb[$];
    frame_t cur;
    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    bit     mon_en = 1'b0;
    bit     mon_active = 1'b0;
    bit     window;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line levels for one frame, from the framing rules.
    function automatic frame_t model(input logic [DW-1:0] d, input bit pe, input bit pt,
                                     input bit s2, input int pre);
        frame_t f;
        int n = 0;
        f.bits = '0;
        f.per = pre + 1;
        f.bits[n] = 1'b0; n++;
        for (int i = 0; i < DW; i++) begin
            f.bits[n] = d[i]; n++;
        end
        if (pe) begin
            f.bits[n] = 1'(($countones(d) % 2) ^ int'(pt)); n++;
        end
        f.bits[n] = 1'b1; n++;
        if (s2) begin
            f.bits[n] = 1'b1; n++;
        end
        f.nbits = n;
        return f;
    endfunction

    // Monitor: samples 2 time units after each falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (mon_en) begin
                window = !mon_active || (cyc == cur.nbits * cur.per - 1);
`ifdef UART_TX_BREAK_EN
                if (Send_Break && !mon_active) window = 1'b0;
`endif
                check("data_ack", Data_Ack, Data_Valid && window);
                if (mon_active) begin
                    check("tx_bit", TX_OUT, cur.bits[cyc / cur.per]);
                    check("busy_frame", busy, 1);
                    cyc++;
                    if (cyc == cur.nbits * cur.per) mon_active = 1'b0;
                end else begin
                    check("tx_idle", TX_OUT, 1);
                    check("busy_idle", busy, 0);
                end
                if (!mon_active && sb.size() > 0) begin
                    cur = sb.pop_front();
                    cyc = 0;
                    mon_active = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input bit pe, input bit pt, input bit s2,
                        input int pre, input bit keep);
        int n = 0;
        bit got = 1'b0;
        @(negedge CLK);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; Prescale = PW'(pre);
        Data_Valid = 1'b1;
        while (!got && n < 400) begin
            #1;
            if (Data_Ack === 1'b1) begin
                sb.push_back(model(d, pe, pt, s2, pre));
                got = 1'b1;
            end else begin
                @(negedge CLK);
                n++;
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL ack_timeout: got no Data_Ack, expected one for data %0h", d);
            Data_Valid = 1'b0;
        end
        if (!keep) begin
            @(negedge CLK);
            Data_Valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sb.size() > 0 || mon_active) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 3000) begin
            tests++; fails++;
            $display("FAIL idle_timeout: busy %0b, expected line idle", busy);
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        check("rst_tx", TX_OUT, 1);
        check("rst_busy", busy, 0);
        check("rst_ack", Data_Ack, 0);
        @(negedge CLK); #3 RST = 1'b1;
        @(negedge CLK); mon_en = 1'b1;
        repeat (2) @(negedge CLK);

        // Basic frame
        send(8'hA5, 0, 0, 0, 3, 0);
        wait_idle();
        // Parity even / odd with two stop bits
        send(8'h07, 1, 0, 1, 2, 0);
        wait_idle();
        send(8'h07, 1, 1, 1, 2, 0);
        wait_idle();
        // Back-to-back
        send(8'h55, 0, 0, 0, 0, 1);
        send(8'h0F, 0, 0, 0, 0, 0);
        wait_idle();
        // Config isolation: mid-frame changes must not affect the frame on the line
        send(8'h3C, 1, 0, 0, 4, 0);
        repeat (10) @(negedge CLK);
        P_DATA = 8'hC3; PAR_TYP = 1'b1; Prescale = 16'd1; STOP2 = 1'b1;
        wait_idle();
        send(8'hC3, 1, 1, 1, 1, 0);
        wait_idle();

        // Randomised frames, some back-to-back
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(negedge CLK);
                Data_Valid = 1'b0;
                wait_idle();
            end
            send(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                 1'($urandom_range(0, 1)));
        end
        @(negedge CLK);
        Data_Valid = 1'b0;
        wait_idle();

        // Reset mid-frame (during the data bits)
        send(8'hC3, 0, 0, 0, 3, 0);
        repeat (12) @(negedge CLK);
        mon_en = 1'b0;
        #3 RST = 1'b0;
        #1;
        check("midrst_tx", TX_OUT, 1);
        check("midrst_busy", busy, 0);
        sb.delete();
        mon_active = 1'b0;
        @(negedge CLK); #3 RST = 1'b1;
        @(negedge CLK); mon_en = 1'b1;
        send(8'h5A, 1, 0, 0, 2, 0);
        wait_idle();

`ifdef UART_TX_BREAK_EN
        // Break held for 3 bit periods with a 10-bit frame: 10 low bits then one stop bit
        begin
            frame_t f;
            int hold_bits = 3;
            int flen = 1 + DW + 0 + 1 + 0;
            int blen = (hold_bits > flen) ? hold_bits : flen;
            @(negedge CLK);
            PAR_EN = 1'b0; STOP2 = 1'b0; Prescale = 16'd2; Send_Break = 1'b1;
            f.bits = '0;
            f.bits[blen] = 1'b1;
            f.nbits = blen + 1;
            f.per = 3;
            #1 sb.push_back(f);
            repeat (hold_bits * 3) @(negedge CLK);
            Send_Break = 1'b0;
            wait_idle();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
